// File: rtl/spi_odata_fifo.sv
// spi_odata_fifo: ordered result buffer feeding the SPI slave output word, with fill count and sticky flags.
// Build option: define SPI_ODFIFO_OVERWRITE_EN to drop the oldest word instead of refusing pushes when full.
module spi_odata_fifo #(
   parameter int                    DATA_WIDTH = 24,
   parameter int                    DEPTH      = 8,
   parameter logic [DATA_WIDTH-1:0] EMPTY_WORD = 24'hFFFFFF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        res_data,
   input  logic                         res_valid,
   output logic                         res_ready,
   output logic [DATA_WIDTH-1:0]        SPI_Odata,
   input  logic                         SPI_Odstart,
   output logic [$clog2(DEPTH):0]       fifo_cnt,
   output logic                         ovf_flag,
   output logic                         udf_flag,
   input  logic                         stat_clr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  full, empty, push, pop, drop, rd_adv, ovf_set, udf_set;

   // Push/pop decode and next-state for pointers, count and sticky flags
   always_comb begin
      full     = cnt_q == CW'(DEPTH);
      empty    = cnt_q == '0;
      pop      = SPI_Odstart & ~empty;
      udf_set  = SPI_Odstart & empty;
`ifdef SPI_ODFIFO_OVERWRITE_EN
      res_ready = 1'b1;
      push      = res_valid;
      drop      = push & full & ~pop;
      ovf_set   = drop;
`else
      res_ready = ~full;
      push      = res_valid & ~full;
      drop      = 1'b0;
      ovf_set   = res_valid & full;
`endif
      rd_adv   = pop | drop;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = (push & ~rd_adv) ? cnt_q + CW'(1) : (rd_adv & ~push) ? cnt_q - CW'(1) : cnt_q;
      ovf_d    = ovf_set | (ovf_q & ~stat_clr);
      udf_d    = udf_set | (udf_q & ~stat_clr);
   end

   // Control state with asynchronous reset; storage contents are left alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Word storage written at the write pointer on every accepted push
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= res_data;
   end

   assign SPI_Odata = (cnt_q == '0) ? EMPTY_WORD : mem_q[rd_ptr_q];
   assign fifo_cnt  = cnt_q;
   assign ovf_flag  = ovf_q;
   assign udf_flag  = udf_q;
endmodule

// File: tb/tb_spi_odata_fifo.sv
// tb_spi_odata_fifo: directed vector table plus hand-written full/wrap/reset sequences for spi_odata_fifo.
module tb_spi_odata_fifo;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] res_data = '0;
   logic        res_valid = 1'b0;
   logic        res_ready;
   logic [23:0] SPI_Odata;
   logic        SPI_Odstart = 1'b0;
   logic [3:0]  fifo_cnt;
   logic        ovf_flag, udf_flag;
   logic        stat_clr = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [23:0] q [$];

   spi_odata_fifo dut (
      .clk(clk), .rst(rst), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .SPI_Odata(SPI_Odata), .SPI_Odstart(SPI_Odstart), .fifo_cnt(fifo_cnt),
      .ovf_flag(ovf_flag), .udf_flag(udf_flag), .stat_clr(stat_clr)
   );

   always #2 clk = ~clk;

   typedef struct {
      logic        v;
      logic [23:0] d;
      logic        s;
      logic        c;
      logic [23:0] e_data;
      logic [3:0]  e_cnt;
      logic        e_rdy;
      logic        e_ovf;
      logic        e_udf;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [23:0] d, input logic [3:0] c,
                          input logic r, input logic o, input logic u);
      chk({name, ".odata"}, 32'(SPI_Odata), 32'(d));
      chk({name, ".cnt"}, 32'(fifo_cnt), 32'(c));
      chk({name, ".ready"}, 32'(res_ready), 32'(r));
      chk({name, ".ovf"}, 32'(ovf_flag), 32'(o));
      chk({name, ".udf"}, 32'(udf_flag), 32'(u));
   endtask

   task automatic step(input logic v, input logic [23:0] d, input logic s, input logic c);
      res_valid = v; res_data = d; SPI_Odstart = s; stat_clr = c;
      @(posedge clk); #1;
      res_valid = 1'b0; SPI_Odstart = 1'b0; stat_clr = 1'b0;
   endtask

   initial begin
      vec_t tbl [10];
      tbl[0] = '{1, 24'h123456, 0, 0, 24'h123456, 1, 1, 0, 0};
      tbl[1] = '{1, 24'hABCDEF, 0, 0, 24'h123456, 2, 1, 0, 0};
      tbl[2] = '{0, 24'h0,      0, 0, 24'h123456, 2, 1, 0, 0};
      tbl[3] = '{0, 24'h0,      1, 0, 24'hABCDEF, 1, 1, 0, 0};
      tbl[4] = '{0, 24'h0,      0, 0, 24'hABCDEF, 1, 1, 0, 0};
      tbl[5] = '{0, 24'h0,      0, 0, 24'hABCDEF, 1, 1, 0, 0};
      tbl[6] = '{0, 24'h0,      1, 0, 24'hFFFFFF, 0, 1, 0, 0};
      tbl[7] = '{0, 24'h0,      1, 0, 24'hFFFFFF, 0, 1, 0, 1};
      tbl[8] = '{0, 24'h0,      1, 1, 24'hFFFFFF, 0, 1, 0, 1};
      tbl[9] = '{0, 24'h0,      0, 1, 24'hFFFFFF, 0, 1, 0, 0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_all("reset", 24'hFFFFFF, 0, 1, 0, 0);

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].c);
         chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_ovf, tbl[i].e_udf);
      end

      for (int k = 1; k <= 8; k++) step(1, 24'(k), 0, 0);
`ifdef SPI_ODFIFO_OVERWRITE_EN
      chk_all("full8", 24'h000001, 8, 1, 0, 0);
      step(1, 24'h000009, 0, 0);
      chk_all("ovw_push9", 24'h000002, 8, 1, 1, 0);
`else
      chk_all("full8", 24'h000001, 8, 0, 0, 0);
      step(1, 24'h000009, 0, 0);
      chk_all("refuse9", 24'h000001, 8, 0, 1, 0);
      step(1, 24'h000009, 1, 0);
      chk_all("pop_full", 24'h000002, 7, 1, 1, 0);
      step(1, 24'h000009, 0, 0);
      chk_all("accept9", 24'h000002, 8, 0, 1, 0);
`endif
      for (int k = 2; k <= 9; k++) begin
         chk($sformatf("order%0d", k), 32'(SPI_Odata), k);
         step(0, 24'h0, 1, 0);
      end
      chk_all("drained", 24'hFFFFFF, 0, 1, 1, 0);
      step(0, 24'h0, 0, 1);
      chk("ovf_clr", 32'(ovf_flag), 0);

      for (int k = 0; k < 3; k++) begin
         step(1, 24'h000100 + 24'(k), 0, 0);
         q.push_back(24'h000100 + 24'(k));
      end
      chk("prewrap_cnt", 32'(fifo_cnt), 3);
      for (int i = 0; i < 20; i++) begin
         step(1, 24'h000200 + 24'(i), 1, 0);
         void'(q.pop_front());
         q.push_back(24'h000200 + 24'(i));
         chk($sformatf("wrap%0d.odata", i), 32'(SPI_Odata), 32'(q[0]));
         chk($sformatf("wrap%0d.cnt", i), 32'(fifo_cnt), 3);
      end
      chk("wrap_ovf", 32'(ovf_flag), 0);
      chk("wrap_udf", 32'(udf_flag), 0);

      step(0, 24'h0, 1, 0);
      #1 rst = 1'b1;
      #1;
      chk_all("midreset", 24'hFFFFFF, 0, 1, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 24'h5A5A5A, 0, 0);
      chk_all("post_reset_push", 24'h5A5A5A, 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
